// File: rtl/modulation_sequencer.sv
// Sample-index and segment sequencer feeding the modulation multiplier.
// Optional GPIO-triggered switching is built when MODULATION_SEQUENCER_GPIO_EN is defined.
//
// state   | meaning
// IDLE    | nothing playing since reset, STOP high
// RUN     | active segment advancing on divided TICK
// PENDING | switch armed (wrap or GPIO), active segment keeps running
// DONE    | loops exhausted, STOP high, index held
module modulation_sequencer #(
    parameter int IDX_WIDTH = 15,
    parameter int DIV_WIDTH = 16,
    parameter int REP_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TICK,
    input  logic [IDX_WIDTH-1:0] CYCLE_0,
    input  logic [IDX_WIDTH-1:0] CYCLE_1,
    input  logic [DIV_WIDTH-1:0] FREQ_DIV_0,
    input  logic [DIV_WIDTH-1:0] FREQ_DIV_1,
    input  logic                 REQ_VALID,
    input  logic                 REQ_SEGMENT,
    input  logic [1:0]           REQ_MODE,
    input  logic [REP_WIDTH-1:0] REQ_REP,
    output logic                 REQ_READY,
    output logic                 REQ_ERR,
    input  logic                 GPIO_IN,
    output logic [IDX_WIDTH-1:0] IDX_0,
    output logic [IDX_WIDTH-1:0] IDX_1,
    output logic                 SEGMENT,
    output logic                 STOP
);

    typedef enum logic [1:0] {IDLE, RUN, PENDING, DONE} state_t;

    localparam logic [1:0] MODE_IMM  = 2'd0;
    localparam logic [1:0] MODE_SYNC = 2'd1;
    localparam logic [1:0] MODE_GPIO = 2'd2;

    state_t               state;
    logic [DIV_WIDTH-1:0] div_0, div_1;
    logic [REP_WIDTH-1:0] loop_cnt;
    logic                 pend_seg, pend_gpio;
    logic [REP_WIDTH-1:0] pend_rep;
    logic                 gpio_edge;

    logic [IDX_WIDTH-1:0] act_idx, act_cycle;
    logic [DIV_WIDTH-1:0] act_div, act_fdiv, div_max;
    logic                 running, adv, wrap_evt, accept, mode_ok;
    logic                 apply_now, arm, pend_fire, apply;
    logic                 tgt_seg;
    logic [REP_WIDTH-1:0] tgt_rep;

`ifdef MODULATION_SEQUENCER_GPIO_EN
    logic gpio_s1, gpio_s2, gpio_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            gpio_s1   <= 1'b0;
            gpio_s2   <= 1'b0;
            gpio_prev <= 1'b0;
        end else begin
            gpio_s1   <= GPIO_IN;
            gpio_s2   <= gpio_s1;
            gpio_prev <= gpio_s2;
        end
    end

    assign gpio_edge = gpio_s2 & ~gpio_prev;
    assign mode_ok   = (REQ_MODE != 2'd3);
`else
    logic unused_gpio;
    assign unused_gpio = GPIO_IN;
    assign gpio_edge   = 1'b0;
    assign mode_ok     = (REQ_MODE == MODE_IMM) || (REQ_MODE == MODE_SYNC);
`endif

    always_comb begin
        act_idx   = SEGMENT ? IDX_1 : IDX_0;
        act_cycle = SEGMENT ? CYCLE_1 : CYCLE_0;
        act_div   = SEGMENT ? div_1 : div_0;
        act_fdiv  = SEGMENT ? FREQ_DIV_1 : FREQ_DIV_0;
        div_max   = (act_fdiv == '0) ? '0 : act_fdiv - DIV_WIDTH'(1);
        running   = ((state == RUN) || (state == PENDING)) && !STOP;
        // >= so a divider lowered live terminates instead of rolling over
        adv       = running && TICK && (act_div >= div_max);
        wrap_evt  = adv && (act_idx >= act_cycle);
        accept    = REQ_VALID && REQ_READY;
        apply_now = accept && mode_ok &&
                    ((REQ_MODE == MODE_IMM) ||
                     ((REQ_MODE == MODE_SYNC) && ((state != RUN) || wrap_evt)));
        arm       = accept && mode_ok && !apply_now;
        pend_fire = (state == PENDING) && (pend_gpio ? gpio_edge : wrap_evt);
        apply     = apply_now || pend_fire;
        tgt_seg   = apply_now ? REQ_SEGMENT : pend_seg;
        tgt_rep   = apply_now ? REQ_REP : pend_rep;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            IDX_0     <= '0;
            IDX_1     <= '0;
            div_0     <= '0;
            div_1     <= '0;
            loop_cnt  <= '0;
            SEGMENT   <= 1'b0;
            STOP      <= 1'b1;
            REQ_READY <= 1'b1;
            REQ_ERR   <= 1'b0;
            pend_seg  <= 1'b0;
            pend_gpio <= 1'b0;
            pend_rep  <= '0;
        end else begin
            REQ_ERR <= accept && !mode_ok;
            if (apply) begin
                SEGMENT <= tgt_seg;
                if (tgt_seg) begin
                    IDX_1 <= '0;
                    div_1 <= '0;
                end else begin
                    IDX_0 <= '0;
                    div_0 <= '0;
                end
                loop_cnt  <= tgt_rep;
                STOP      <= 1'b0;
                state     <= RUN;
                REQ_READY <= 1'b1;
            end else begin
                if (running && TICK) begin
                    if (adv) begin
                        if (SEGMENT) div_1 <= '0;
                        else         div_0 <= '0;
                        if (!wrap_evt) begin
                            if (SEGMENT) IDX_1 <= IDX_1 + IDX_WIDTH'(1);
                            else         IDX_0 <= IDX_0 + IDX_WIDTH'(1);
                        end else if (&loop_cnt) begin
                            if (SEGMENT) IDX_1 <= '0;
                            else         IDX_0 <= '0;
                        end else if (loop_cnt == '0) begin
                            // a pending GPIO switch outlives the stop, so stay PENDING
                            STOP <= 1'b1;
                            if (state == RUN) state <= DONE;
                        end else begin
                            if (SEGMENT) IDX_1 <= '0;
                            else         IDX_0 <= '0;
                            loop_cnt <= loop_cnt - REP_WIDTH'(1);
                        end
                    end else begin
                        if (SEGMENT) div_1 <= div_1 + DIV_WIDTH'(1);
                        else         div_0 <= div_0 + DIV_WIDTH'(1);
                    end
                end
                if (arm) begin
                    state     <= PENDING;
                    REQ_READY <= 1'b0;
                    pend_seg  <= REQ_SEGMENT;
                    pend_gpio <= (REQ_MODE == MODE_GPIO);
                    pend_rep  <= REQ_REP;
                end
            end
        end
    end

endmodule
